// File: rtl/alu_pkg.sv
// alu_mc shared definitions: op-code encoding and control states.
// Codes at or above ALU_OP_ILLEGAL_MIN are reported through out_err.
package alu_pkg;

   typedef enum logic [4:0] {
      OP_BEQ    = 5'd0,
      OP_BNE    = 5'd1,
      OP_BLT    = 5'd2,
      OP_BGE    = 5'd3,
      OP_BLTU   = 5'd4,
      OP_BGEU   = 5'd5,
      OP_ADD    = 5'd6,
      OP_SUB    = 5'd7,
      OP_SLL    = 5'd8,
      OP_SLT    = 5'd9,
      OP_SLTU   = 5'd10,
      OP_XOR    = 5'd11,
      OP_SRL    = 5'd12,
      OP_SRA    = 5'd13,
      OP_OR     = 5'd14,
      OP_AND    = 5'd15,
      OP_MUL    = 5'd16,
      OP_MULH   = 5'd17,
      OP_MULHSU = 5'd18,
      OP_MULHU  = 5'd19
   } alu_op_e;

   localparam logic [4:0] ALU_OP_ILLEGAL_MIN = 5'd20;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_HOLD = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: magnitudes in, one partial product per
// cycle, product negated at the end when operand signs differ.
module alu_mul_iter #(
   parameter int XLEN = 32
) (
   input  logic            soc_clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            a_signed,
   input  logic            b_signed,
   input  logic            hi_sel,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;

   logic [CW-1:0]     cnt;
   logic              run;
   logic              neg;
   logic              hi_q;
   logic [XLEN-1:0]   mcand;
   logic [2*XLEN-1:0] acc;
   logic [XLEN:0]     sum;
   logic [2*XLEN-1:0] prod;
   logic              a_neg;
   logic              b_neg;

   assign a_neg = a_signed & a[XLEN-1];
   assign b_neg = b_signed & b[XLEN-1];
   assign done  = run && (cnt == CW'(XLEN));

   // acc holds {partial high, remaining multiplier bits}
   always_comb begin
      sum = {1'b0, acc[2*XLEN-1:XLEN]};
      if (acc[0])
         sum = sum + {1'b0, mcand};
      prod   = neg ? -acc : acc;
      result = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
   end

   always_ff @(posedge soc_clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         run   <= 1'b0;
         neg   <= 1'b0;
         hi_q  <= 1'b0;
         mcand <= '0;
         acc   <= '0;
      end else if (start) begin
         cnt   <= '0;
         run   <= 1'b1;
         neg   <= a_neg ^ b_neg;
         hi_q  <= hi_sel;
         mcand <= a_neg ? -a : a;
         acc   <= {{XLEN{1'b0}}, (b_neg ? -b : b)};
      end else if (done) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (run) begin
         acc <= {sum, acc[XLEN-1:1]};
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: single-cycle RV32I ops inline, RV32M multiplies
// through alu_mul_iter, result held with flags until taken.
module alu_mc
   import alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int MUL_EN = 1
) (
   input  logic            soc_clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] dat1,
   input  logic [XLEN-1:0] dat2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_con_met,
   output logic            out_zero,
   output logic            out_overflow,
   output logic            out_err,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);
   localparam int M   = XLEN - 1;

   alu_state_e      state;
   logic            accept;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;
   logic [SHW-1:0]  shamt;
   logic            lt_s;
   logic            lt_u;
   logic            eq;
   logic [XLEN-1:0] res;
   logic            con;
   logic            ovf;
   logic            err;
   logic            zero;
   logic            is_mul;
   logic            mul_hi;
   logic            a_s;
   logic            b_s;
   logic            mul_done;
   logic [XLEN-1:0] mul_res;

   assign in_ready  = reset_n &&
                      (state == ST_IDLE || (state == ST_HOLD && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == ST_HOLD);
   assign busy      = (state != ST_IDLE);

   assign sum   = dat1 + dat2;
   assign diff  = dat1 - dat2;
   assign shamt = dat2[SHW-1:0];
   assign lt_s  = $signed(dat1) < $signed(dat2);
   assign lt_u  = dat1 < dat2;
   assign eq    = dat1 == dat2;

   always_comb begin
      res    = '0;
      con    = 1'b0;
      ovf    = 1'b0;
      err    = 1'b0;
      is_mul = 1'b0;
      mul_hi = 1'b0;
      a_s    = 1'b0;
      b_s    = 1'b0;
      unique case (op)
         OP_BEQ:  con = eq;
         OP_BNE:  con = !eq;
         OP_BLT:  con = lt_s;
         OP_BGE:  con = !lt_s;
         OP_BLTU: con = lt_u;
         OP_BGEU: con = !lt_u;
         OP_ADD: begin
            res = sum;
            ovf = (dat1[M] == dat2[M]) && (sum[M] != dat1[M]);
         end
         OP_SUB: begin
            res = diff;
            ovf = (dat1[M] != dat2[M]) && (diff[M] != dat1[M]);
         end
         OP_SLL: res = dat1 << shamt;
         OP_SLT: begin
            con = lt_s;
            res = XLEN'(lt_s);
         end
         OP_SLTU: begin
            con = lt_u;
            res = XLEN'(lt_u);
         end
         OP_XOR: res = dat1 ^ dat2;
         OP_SRL: res = dat1 >> shamt;
         OP_SRA: res = $unsigned($signed(dat1) >>> shamt);
         OP_OR:  res = dat1 | dat2;
         OP_AND: res = dat1 & dat2;
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: begin
            is_mul = (MUL_EN != 0);
            err    = (MUL_EN == 0);
            mul_hi = (op != OP_MUL);
            a_s    = (op == OP_MULH) || (op == OP_MULHSU);
            b_s    = (op == OP_MULH);
         end
         default: err = 1'b1;
      endcase
      zero = !err && (res == '0);
   end

   alu_mul_iter #(
      .XLEN(XLEN)
   ) u_mul (
      .soc_clk (soc_clk),
      .reset_n (reset_n),
      .start   (accept && is_mul),
      .a       (dat1),
      .b       (dat2),
      .a_signed(a_s),
      .b_signed(b_s),
      .hi_sel  (mul_hi),
      .done    (mul_done),
      .result  (mul_res)
   );

   always_ff @(posedge soc_clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         out_result   <= '0;
         out_con_met  <= 1'b0;
         out_zero     <= 1'b0;
         out_overflow <= 1'b0;
         out_err      <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE, ST_HOLD: begin
               if (accept && is_mul) begin
                  state <= ST_MUL;
               end else if (accept) begin
                  state        <= ST_HOLD;
                  out_result   <= res;
                  out_con_met  <= con;
                  out_zero     <= zero;
                  out_overflow <= ovf;
                  out_err      <= err;
               end else if (state == ST_HOLD && out_ready) begin
                  state <= ST_IDLE;
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  state        <= ST_HOLD;
                  out_result   <= mul_res;
                  out_con_met  <= 1'b0;
                  out_zero     <= (mul_res == '0);
                  out_overflow <= 1'b0;
                  out_err      <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed bench for alu_mc against an arithmetic model.
module tb_alu_mc;

   logic        soc_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  op = '0;
   logic [31:0] dat1 = '0;
   logic [31:0] dat2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic        out_con_met, out_zero, out_overflow, out_err, busy;

   logic        n_in_valid = 1'b0;
   logic        n_in_ready;
   logic [4:0]  n_op = '0;
   logic        n_out_valid;
   logic [31:0] n_out_result;
   logic        n_con, n_zero, n_ovf, n_err, n_busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [31:0] res;
      bit          con, zero, ovf, err;
      int          acc;
      int          lat;
   } exp_t;

   exp_t q[$];

   alu_mc #(.XLEN(32), .MUL_EN(1)) dut (
      .soc_clk(soc_clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .dat1(dat1), .dat2(dat2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_con_met(out_con_met),
      .out_zero(out_zero), .out_overflow(out_overflow),
      .out_err(out_err), .busy(busy)
   );

   alu_mc #(.XLEN(32), .MUL_EN(0)) dut_nomul (
      .soc_clk(soc_clk), .reset_n(reset_n),
      .in_valid(n_in_valid), .in_ready(n_in_ready),
      .op(n_op), .dat1(32'h5), .dat2(32'h7),
      .out_valid(n_out_valid), .out_ready(1'b1),
      .out_result(n_out_result), .out_con_met(n_con),
      .out_zero(n_zero), .out_overflow(n_ovf),
      .out_err(n_err), .busy(n_busy)
   );

   always #5 soc_clk = ~soc_clk;
   always @(posedge soc_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [4:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t        e;
      longint      sa, sb, ua, s;
      logic [63:0] p;
      e  = '{res: '0, con: 0, zero: 0, ovf: 0, err: 0, acc: 0, lat: 0};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      s  = 0;
      p  = '0;
      case (o)
         5'd0:  e.con = (a == b);
         5'd1:  e.con = (a != b);
         5'd2:  e.con = (sa < sb);
         5'd3:  e.con = (sa >= sb);
         5'd4:  e.con = (a < b);
         5'd5:  e.con = (a >= b);
         5'd6: begin
            s = sa + sb;
            e.res = s[31:0];
            e.ovf = (s != longint'($signed(s[31:0])));
         end
         5'd7: begin
            s = sa - sb;
            e.res = s[31:0];
            e.ovf = (s != longint'($signed(s[31:0])));
         end
         5'd8:  e.res = a << b[4:0];
         5'd9:  begin e.con = (sa < sb); e.res = {31'h0, e.con}; end
         5'd10: begin e.con = (a < b);   e.res = {31'h0, e.con}; end
         5'd11: e.res = a ^ b;
         5'd12: e.res = a >> b[4:0];
         5'd13: e.res = $unsigned($signed(a) >>> b[4:0]);
         5'd14: e.res = a | b;
         5'd15: e.res = a & b;
         5'd16: begin p = sa * sb; e.res = p[31:0]; end
         5'd17: begin p = sa * sb; e.res = p[63:32]; end
         5'd18: begin p = sa * longint'({32'h0, b}); e.res = p[63:32]; end
         5'd19: begin p = {32'h0, a} * {32'h0, b}; e.res = p[63:32]; end
         default: e.err = 1;
      endcase
      if (ua < 0) e.err = 1;
      e.zero = !e.err && (e.res == 0);
      e.lat  = (o >= 5'd16 && o <= 5'd19) ? 33 : 0;
      return e;
   endfunction

   // compare process: one item outstanding from accept until take
   always @(negedge soc_clk) begin
      bit   vis;
      exp_t e;
      if (!reset_n) begin
         q.delete();
         chk("rst out_valid", out_valid, 0);
         chk("rst in_ready", in_ready, 0);
         chk("rst busy", busy, 0);
         chk("rst result", out_result, 0);
         chk("rst flags", {out_con_met, out_zero, out_overflow, out_err}, 0);
      end else begin
         vis = (q.size() > 0) && (cyc - q[0].acc >= q[0].lat);
         chk("out_valid", out_valid, vis);
         chk("busy", busy, q.size() > 0);
         chk("in_ready", in_ready, (q.size() == 0) || (vis && out_ready));
         if (vis && out_valid) begin
            chk("result", out_result, q[0].res);
            chk("con_met", out_con_met, q[0].con);
            chk("zero", out_zero, q[0].zero);
            chk("overflow", out_overflow, q[0].ovf);
            chk("err", out_err, q[0].err);
         end
         if (vis && out_valid && out_ready)
            void'(q.pop_front());
         if (in_valid && in_ready) begin
            e     = model(op, dat1, dat2);
            e.acc = cyc + 1;
            q.push_back(e);
         end
      end
   end

   task automatic send(input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit keep,
                       output int acc_cyc);
      bit ok;
      ok       = 0;
      in_valid = 1'b1;
      op       = o;
      dat1     = a;
      dat2     = b;
      acc_cyc  = -1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge soc_clk);
         ok = in_ready;
         @(posedge soc_clk);
         #1;
      end
      if (!ok) chk("accept timeout", 0, 1);
      else acc_cyc = cyc;
      if (!keep) in_valid = 1'b0;
   endtask

   initial begin
      exp_t        e;
      int          c0, c1, c2, c3;
      logic [31:0] hold_r;
      logic [3:0]  hold_f;
      logic [31:0] pick [6];
      bit          acc;

      e = model(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("model mulhu", e.res, 32'hFFFFFFFE);
      e = model(5'd6, 32'h7FFFFFFF, 32'h1);
      chk("model add ovf", {e.res, 31'h0, e.ovf}, {32'h80000000, 32'h1});
      e = model(5'd13, 32'h80000000, 32'h21);
      chk("model sra", e.res, 32'hC0000000);

      repeat (3) @(posedge soc_clk);
      #1;
      chk("reset in_ready", in_ready, 0);
      reset_n = 1'b1;
      #1;
      chk("in_ready after release", in_ready, 1);

      send(5'd6, 32'h7FFFFFFF, 32'h1, 0, c0);
      chk("add valid", out_valid, 1);
      chk("add result", out_result, 32'h80000000);
      chk("add ovf/zero", {out_overflow, out_zero}, 2'b10);

      send(5'd7, 32'd5, 32'd5, 1, c0);
      chk("sub result", out_result, 0);
      chk("sub zero", out_zero, 1);
      send(5'd2, 32'hFFFFFFFF, 32'd1, 1, c1);
      chk("blt con", {out_con_met, out_zero}, 2'b11);
      send(5'd13, 32'h80000000, 32'h21, 0, c2);
      chk("sra result", out_result, 32'hC0000000);
      chk("b2b rate", {c1 - c0, c2 - c1}, {32'd1, 32'd1});

      foreach (pick[i]) pick[i] = 0;
      send(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, c0);
      for (int k = 1; k <= 33; k++) begin
         @(posedge soc_clk);
         #1;
         if (k < 33) chk("mulh wait", {out_valid, in_ready}, 0);
      end
      chk("mulh valid", out_valid, 1);
      chk("mulh result", out_result, 0);
      send(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, c1);
      chk("mulhu latency", c1 - c0, 34);
      for (int k = 1; k <= 33; k++) begin
         @(posedge soc_clk);
         #1;
         if (k < 33) chk("mulhu wait", {out_valid, in_ready}, 0);
      end
      chk("mulhu result", {out_valid, out_result}, {1'b1, 32'hFFFFFFFE});

      send(5'd14, 32'hF0F00000, 32'h0000000F, 0, c0);
      out_ready = 1'b0;
      hold_r = out_result;
      hold_f = {out_con_met, out_zero, out_overflow, out_err};
      chk("or result", hold_r, 32'hF0F0000F);
      repeat (5) begin
         @(posedge soc_clk);
         #1;
         chk("bp stable", out_result, hold_r);
         chk("bp flags", {out_con_met, out_zero, out_overflow, out_err}, hold_f);
         chk("bp in_ready", {out_valid, in_ready}, 2'b10);
      end
      out_ready = 1'b1;
      send(5'd15, 32'hFF00FF00, 32'h0FF00FF0, 0, c1);
      chk("bp accept edge", c1 - c0, 6);
      chk("and result", out_result, 32'h0F000F00);

      send(5'd25, 32'h1234, 32'h5678, 0, c0);
      chk("illegal", {out_valid, out_err, out_zero, out_result}, {3'b110, 32'h0});

      chk("nomul ready", n_in_ready, 1);
      n_in_valid = 1'b1;
      n_op = 5'd16;
      @(posedge soc_clk);
      #1;
      n_in_valid = 1'b0;
      chk("nomul mul", {n_out_valid, n_err, n_zero, n_out_result},
          {3'b110, 32'h0});

      send(5'd16, 32'd1234, 32'd5678, 0, c0);
      repeat (10) @(posedge soc_clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("abort outputs", {out_valid, in_ready, busy, out_result},
          {3'b000, 32'h0});
      repeat (2) @(posedge soc_clk);
      #1;
      reset_n = 1'b1;
      repeat (40) begin
         @(negedge soc_clk);
         chk("abort no valid", out_valid, 0);
      end
      @(posedge soc_clk);
      #1;
      send(5'd6, 32'd2, 32'd3, 0, c0);
      chk("add after abort", {out_valid, out_result}, {1'b1, 32'd5});

      pick[0] = 32'h0;
      pick[1] = 32'h1;
      pick[2] = 32'hFFFFFFFF;
      pick[3] = 32'h80000000;
      pick[4] = 32'h7FFFFFFF;
      for (int n = 0; n < 600; n++) begin
         @(negedge soc_clk);
         acc = in_valid && in_ready;
         @(posedge soc_clk);
         #1;
         if (acc || !in_valid) begin
            in_valid = ($urandom_range(0, 3) != 0);
            op = 5'($urandom_range(0, 23));
            pick[5] = $urandom;
            dat1 = pick[$urandom_range(0, 5)];
            pick[5] = $urandom;
            dat2 = pick[$urandom_range(0, 5)];
         end
         out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      c3 = 0;
      for (int n = 0; n < 100 && q.size() > 0; n++) begin
         @(posedge soc_clk);
         c3 = n;
      end
      #1;
      chk("drain", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU: the next-generation execute unit between the CU operand registers and CU writeback. It accepts one operation per valid/ready handshake, computes RV32I integer/compare/branch ops in one cycle and, when enabled, RV32M multiplies iteratively. Results are held with flags until the CU takes them. It adds width parametrisation, illegal-op reporting and output backpressure.

## Interface
- `XLEN`, default 32: operand/result width; power of two, ≥8.
- `MUL_EN`, default 1: 1 enables ops 16–19; 0 makes them illegal.
- `soc_clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: op/operands valid.
- `in_ready` out 1: ALU can accept; transfer on `in_valid && in_ready` at a rising edge.
- `op` in 5: operation code (alu_pkg encoding).
- `dat1`, `dat2` in XLEN: operands (rs1, rs2/imm).
- `out_valid` out 1: result and flags valid, held until taken.
- `out_ready` in 1: CU takes result on `out_valid && out_ready`.
- `out_result` out XLEN: result.
- `out_con_met` out 1: branch-taken / SLT condition.
- `out_zero` out 1: `out_result == 0`.
- `out_overflow` out 1: signed overflow (ADD/SUB only).
- `out_err` out 1: illegal op.
- `busy` out 1: state ≠ IDLE.

## Operation
- Op codes: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 ADD, 7 SUB, 8 SLL, 9 SLT, 10 SLTU, 11 XOR, 12 SRL, 13 SRA, 14 OR, 15 AND, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU. Codes 20–31 are illegal.
- Branch ops 0–5: `out_con_met` = condition, `out_result` = 0, `out_zero` = 1.
- SLT/SLTU: `out_result` = {0…, cond}; `out_con_met` = cond.
- ADD/SUB: result is modulo 2^XLEN. `out_overflow` is set when the operand signs give a wrong-signed result (ADD: same-sign operands; SUB: opposite-sign operands). It is 0 for all other ops.
- Shifts: shift amount is `dat2[$clog2(XLEN)-1:0]`; upper bits are ignored. SRA sign-fills.
- MUL returns the low XLEN bits of the product. MULH, MULHSU and MULHU return the high XLEN bits with operand signedness s×s, s×u and u×u.
- Illegal op (or 16–19 with `MUL_EN`=0): `out_err` = 1, `out_result` = 0, other flags 0, single-cycle latency.
- States:
  - IDLE: accept. Single-cycle op → HOLD. Multiply → MUL.
  - MUL: XLEN shift-add iterations, then sign fix-up → HOLD.
  - HOLD: `out_valid` = 1. On `out_ready`, go to IDLE, or directly to MUL/HOLD if a new op is accepted the same edge.
- `in_ready` = (IDLE) or (HOLD and `out_ready`), forced 0 while `reset_n` = 0.
- `out_*` registers are stable while `out_valid && !out_ready`.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0, including `in_ready`.
- `in_ready` becomes 1 in the first cycle after release.
- Single-cycle op accepted at edge N: `out_valid` = 1 after edge N; back-to-back throughput is 1 op/cycle when `out_ready` is held high.
- Multiply accepted at edge N: iterations occur on edges N+1…N+XLEN; fix-up and output register on edge N+XLEN+1; `out_valid` is asserted after that edge. `in_ready` = 0 throughout.
- `reset_n` low mid-multiply aborts the op: no result is produced and the counter clears.
- `in_valid` while `in_ready` = 0 is ignored; the upstream holds the op.

## Structure
- `alu_pkg`: op-code enum (`alu_op_e`), `ALU_OP_ILLEGAL_MIN` = 20, and the state enum (IDLE/MUL/HOLD).
- One sub-module, `alu_mul_iter`, containing:
  - unsigned shift-add datapath with a 2·XLEN accumulator and `$clog2(XLEN)+1` counter;
  - start/done handshake;
  - sign handling (negate magnitudes at start, negate product at end).
- Single-cycle datapath is inline in `alu_mc`.

## Test plan
- Reset release, then ADD 0x7FFFFFFF+1 with `out_ready`=1 → `out_result` 0x80000000, `out_overflow` 1, `out_zero` 0, `out_valid` one cycle after accept.
- Back-to-back SUB 5−5, BLT −1<1, SRA 0x80000000 by dat2=0x21 on consecutive cycles → results:
  - SUB: 0, zero 1;
  - BLT: `out_con_met` 1;
  - SRA: shift of 1 → 0xC0000000.
  - 1 op/cycle throughout.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0, and MULHU same operands → 0xFFFFFFFE. Each has `out_valid` exactly XLEN+1 edges after accept, with `in_ready` 0 meanwhile.
- Backpressure: hold `out_ready`=0 for 5 cycles after an OR result → `out_result`/flags stable, `in_ready` 0; new op accepted on the same edge `out_ready` rises.
- Op 25, then op 16 with `MUL_EN`=0 → `out_err` 1, result 0, 1-cycle latency each.
- `reset_n` pulsed low at iteration 10 of MUL → outputs 0 immediately, no `out_valid`; next ADD 2+3 returns 5 normally.
